// File: rtl/perf_cnt_mmio_reader_if.sv
// CPU load/store port of the perf-counter register block.
// Latency: n/a (signal bundle only).
// Backpressure: none; re/we are single-cycle strobes, rd_valid acknowledges reads.
interface perf_cnt_mmio_reader_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      addr;
  logic             re;
  logic             we;
  logic [CNT_W-1:0] wdata;
  logic [CNT_W-1:0] rdata;
  logic             rd_valid;

  modport master (output addr, re, we, wdata, input rdata, rd_valid);
  modport slave  (input addr, re, we, wdata, output rdata, rd_valid);
endinterface

// File: rtl/perf_cnt_mmio_reader.sv
// Memory-mapped snapshot/clear/LFSR responder for branch-predictor counters.
// Latency: reads answered exactly 1 cycle after re; clr_cnts 1 cycle after the CLR write.
// Backpressure: none; every in-range access is accepted in its strobe cycle.
module perf_cnt_mmio_reader #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  perf_cnt_mmio_reader_if.slave bus,
  input  logic [CNT_W-1:0]     br_cnt_in,
  input  logic [CNT_W-1:0]     hit_cnt_in,
  input  logic [CNT_W-1:0]     mispr_cnt_in,
  input  logic [CNT_W-1:0]     timer_in,
  output logic                 clr_cnts
);

  logic [15:0]      off;
  logic             in_range;
  logic             wr_en;
  logic             rd_en;
  logic             wr_ctrl;
  logic             snap_load;
  logic [CNT_W-1:0] rd_mux;

  logic [CNT_W-1:0] br_snap_q;
  logic [CNT_W-1:0] hit_snap_q;
  logic [CNT_W-1:0] mispr_snap_q;
  logic [CNT_W-1:0] timer_snap_q;
  logic [CNT_W-1:0] age_q;
  logic [15:0]      lfsr_q;
  logic             auto_q;
  logic             snap_valid_q;

  // Only CTRL consumes write data, and only its low three bits.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[CNT_W-1:3];

  // Offset arithmetic wraps, so anything below BASE_ADDR lands far out of range.
  assign off       = bus.addr - BASE_ADDR;
  assign in_range  = (off[15:3] == 13'd0);
  assign wr_en     = bus.we & in_range;
  // A simultaneous write wins; the read is dropped entirely.
  assign rd_en     = bus.re & ~bus.we & in_range;
  assign wr_ctrl   = wr_en & (off[2:0] == 3'd0);
  // AUTO in force this cycle or an explicit SNAP both capture the live counters.
  assign snap_load = auto_q | (wr_ctrl & bus.wdata[0]);

  // Read mux: value of the addressed register as seen in the re cycle.
  always_comb begin
    rd_mux = '0;
    case (off[2:0])
      3'd0: rd_mux = {{(CNT_W-4){1'b0}}, snap_valid_q, auto_q, 2'b00};
      3'd1: rd_mux = br_snap_q;
      3'd2: rd_mux = hit_snap_q;
      3'd3: rd_mux = mispr_snap_q;
      3'd4: rd_mux = timer_snap_q;
      3'd5: rd_mux = CNT_W'(lfsr_q);
      3'd6: rd_mux = age_q;
      default: rd_mux = '0;
    endcase
  end

  // Registered read response and clear pulse; reset kills any pending ones at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.rdata    <= '0;
      clr_cnts     <= 1'b0;
    end else begin
      bus.rd_valid <= rd_en;
      bus.rdata    <= rd_en ? rd_mux : '0;
      clr_cnts     <= wr_ctrl & bus.wdata[1];
    end
  end

  // Snapshot capture uses the pre-clear live values since the clear lands a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_snap_q    <= '0;
      hit_snap_q   <= '0;
      mispr_snap_q <= '0;
      timer_snap_q <= '0;
      snap_valid_q <= 1'b0;
    end else if (snap_load) begin
      br_snap_q    <= br_cnt_in;
      hit_snap_q   <= hit_cnt_in;
      mispr_snap_q <= mispr_cnt_in;
      timer_snap_q <= timer_in;
      snap_valid_q <= 1'b1;
    end
  end

  // AUTO control bit and the saturating snapshot age counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q <= 1'b0;
      age_q  <= '0;
    end else begin
      if (wr_ctrl) auto_q <= bus.wdata[2];
      if (snap_load)         age_q <= '0;
      else if (age_q != '1)  age_q <= age_q + CNT_W'(1);
    end
  end

  // Free-running Fibonacci LFSR; taps 15,14,12,3 keep it off the all-zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
  end

endmodule

// File: tb/tb_perf_cnt_mmio_reader.sv
// Self-checking bench for perf_cnt_mmio_reader against a timestamp-based reference model.
// Latency: checks each response one cycle after its strobe.
// Backpressure: none modelled; strobes are single-cycle.
module tb_perf_cnt_mmio_reader;
  localparam logic [15:0] BASE = 16'hC000;

  logic        clk;
  logic        rst_n;
  logic [15:0] br_cnt_in, hit_cnt_in, mispr_cnt_in, timer_in;
  logic        clr_cnts;

  perf_cnt_mmio_reader_if #(.CNT_W(16)) bus_if ();

  perf_cnt_mmio_reader #(.BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if.slave),
    .br_cnt_in    (br_cnt_in),
    .hit_cnt_in   (hit_cnt_in),
    .mispr_cnt_in (mispr_cnt_in),
    .timer_in     (timer_in),
    .clr_cnts     (clr_cnts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: register contents plus the cycle index of the last capture.
  logic [15:0] m_snap [4];
  bit          m_auto;
  bit          m_valid;
  int          m_last;
  logic [15:0] m_lfsr;
  int          cyc;

  logic [15:0] last_dat;
  logic        last_vld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] o);
    int age;
    age = cyc - m_last - 1;
    if (age > 65535) age = 65535;
    case (o)
      3'd0: return {12'd0, m_valid, m_auto, 2'b00};
      3'd1, 3'd2, 3'd3, 3'd4: return m_snap[o - 3'd1];
      3'd5: return m_lfsr;
      3'd6: return 16'(age);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_snap[i] = 16'h0000;
    m_auto  = 0;
    m_valid = 0;
    m_last  = -1;
    m_lfsr  = 16'hACE1;
    cyc     = 0;
  endtask

  // One clock cycle with the currently driven inputs; optionally check the response.
  task automatic tick(input bit do_chk);
    logic [15:0] o;
    bit inr, exp_vld, exp_clr, wr_ctrl;
    logic [15:0] exp_dat;
    o       = bus_if.addr - BASE;
    inr     = (o < 16'd8);
    exp_vld = bus_if.re && !bus_if.we && inr;
    exp_dat = exp_vld ? model_read(o[2:0]) : 16'h0000;
    wr_ctrl = bus_if.we && inr && (o == 16'd0);
    exp_clr = wr_ctrl && bus_if.wdata[1];
    if (m_auto || (wr_ctrl && bus_if.wdata[0])) begin
      m_snap[0] = br_cnt_in;
      m_snap[1] = hit_cnt_in;
      m_snap[2] = mispr_cnt_in;
      m_snap[3] = timer_in;
      m_valid   = 1;
      m_last    = cyc;
    end
    if (wr_ctrl) m_auto = bus_if.wdata[2];
    m_lfsr = lfsr_step(m_lfsr);
    @(posedge clk);
    #1;
    cyc++;
    last_dat = bus_if.rdata;
    last_vld = bus_if.rd_valid;
    if (do_chk) begin
      chk("rd_valid", {31'd0, bus_if.rd_valid}, {31'd0, exp_vld});
      chk("rdata", {16'd0, bus_if.rdata}, {16'd0, exp_dat});
      chk("clr_cnts", {31'd0, clr_cnts}, {31'd0, exp_clr});
    end
  endtask

  task automatic rd(input logic [15:0] a);
    bus_if.addr = a; bus_if.re = 1'b1; bus_if.we = 1'b0;
    tick(1);
    bus_if.re = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus_if.addr = a; bus_if.wdata = d; bus_if.we = 1'b1; bus_if.re = 1'b0;
    tick(1);
    bus_if.we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.re = 1'b0; bus_if.we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
    chk("rst_rdata", {16'd0, bus_if.rdata}, 32'd0);
    chk("rst_clr", {31'd0, clr_cnts}, 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus_if.addr = 16'h0; bus_if.re = 1'b0; bus_if.we = 1'b0; bus_if.wdata = 16'h0;
    br_cnt_in = 16'h0; hit_cnt_in = 16'h0; mispr_cnt_in = 16'h0; timer_in = 16'h0;
    last_dat = 16'h0; last_vld = 1'b0;
    model_reset();
    do_reset();

    // LFSR reads in the first two cycles after reset
    rd(BASE + 16'd5);
    chk("lfsr_first", {16'd0, last_dat}, 32'h0000ACE1);
    rd(BASE + 16'd5);
    chk("lfsr_second", {16'd0, last_dat}, 32'h000059C3);
    rd(BASE + 16'd1);
    chk("snap_reset", {16'd0, last_dat}, 32'd0);

    // Snapshot holds after the live counters move
    br_cnt_in = 16'h0010; hit_cnt_in = 16'h000C; mispr_cnt_in = 16'h0004; timer_in = 16'h1234;
    wr(BASE, 16'h0001);
    br_cnt_in = 16'hFFFF; hit_cnt_in = 16'hFFFF; mispr_cnt_in = 16'hFFFF; timer_in = 16'hFFFF;
    rd(BASE + 16'd1); chk("br_snap", {16'd0, last_dat}, 32'h0010);
    rd(BASE + 16'd2); chk("hit_snap", {16'd0, last_dat}, 32'h000C);
    rd(BASE + 16'd3); chk("mispr_snap", {16'd0, last_dat}, 32'h0004);
    rd(BASE + 16'd4); chk("timer_snap", {16'd0, last_dat}, 32'h1234);
    rd(BASE);         chk("ctrl_valid", {16'd0, last_dat}, 32'h0008);

    // Snapshot plus clear in one write
    br_cnt_in = 16'h0020;
    wr(BASE, 16'h0003);
    chk("clr_pulse", {31'd0, clr_cnts}, 32'd1);
    tick(1);
    chk("clr_gone", {31'd0, clr_cnts}, 32'd0);
    rd(BASE + 16'd1); chk("br_snap_clr", {16'd0, last_dat}, 32'h0020);
    rd(BASE);         chk("ctrl_after_clr", {16'd0, last_dat}, 32'h0008);

    // Age counting and saturation
    wr(BASE, 16'h0001);
    repeat (10) tick(0);
    rd(BASE + 16'd6); chk("age_10", {16'd0, last_dat}, 32'h000A);
    repeat (70000) tick(0);
    rd(BASE + 16'd6); chk("age_sat", {16'd0, last_dat}, 32'hFFFF);

    // Address decode
    rd(BASE + 16'd8); chk("oor_hi_vld", {31'd0, last_vld}, 32'd0);
    rd(16'h0000);     chk("oor_zero_vld", {31'd0, last_vld}, 32'd0);
    rd(BASE + 16'd7);
    chk("rsvd_vld", {31'd0, last_vld}, 32'd1);
    chk("rsvd_dat", {16'd0, last_dat}, 32'd0);
    bus_if.addr = BASE; bus_if.wdata = 16'h0004; bus_if.re = 1'b1; bus_if.we = 1'b1;
    tick(1);
    bus_if.re = 1'b0; bus_if.we = 1'b0;
    chk("rw_collide_vld", {31'd0, last_vld}, 32'd0);
    rd(BASE); chk("ctrl_auto", {16'd0, last_dat}, 32'h000C);

    // Auto mode with a ramping branch count, then reset during a read response
    begin
      logic [15:0] prev;
      prev = br_cnt_in;
      for (int k = 0; k < 8; k++) begin
        prev = br_cnt_in;
        br_cnt_in = 16'h0100 + 16'(k);
        if (k == 6) begin
          bus_if.addr = BASE + 16'd1; bus_if.re = 1'b1;
        end
        tick(1);
        bus_if.re = 1'b0;
        if (k == 6) chk("auto_prev", {16'd0, last_dat}, {16'd0, prev});
        if (k == 7) begin
          bus_if.addr = BASE + 16'd1; bus_if.re = 1'b1;
          tick(1);
          bus_if.re = 1'b0;
          chk("pre_rst_vld", {31'd0, bus_if.rd_valid}, 32'd1);
          #2;
          rst_n = 1'b0;
          #1;
          chk("rst_drop_vld", {31'd0, bus_if.rd_valid}, 32'd0);
          chk("rst_drop_dat", {16'd0, bus_if.rdata}, 32'd0);
        end
      end
    end
    do_reset();
    rd(BASE); chk("ctrl_after_rst", {16'd0, last_dat}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      br_cnt_in    = 16'($urandom);
      hit_cnt_in   = 16'($urandom);
      mispr_cnt_in = 16'($urandom);
      timer_in     = 16'($urandom);
      bus_if.addr  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 9));
      bus_if.wdata = 16'($urandom);
      bus_if.re    = 1'($urandom_range(0, 1));
      bus_if.we    = ($urandom_range(0, 4) == 0);
      tick(1);
    end
    bus_if.re = 1'b0; bus_if.we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/perf_cnt_mmio_reader.md
Name: perf_cnt_mmio_reader

Overview:
CPU-side memory-mapped read/control responder for the branch-predictor performance counters. It takes live counter values from the counter block, which provides branch, hit, mispredict and timer counts. It captures them atomically into snapshot registers on CPU command and returns them on the load path with a fixed 1-cycle latency. It also issues the counter clear pulse and hosts the free-running 16-bit LFSR.

Parameters:
BASE_ADDR, 16'hC000, word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+7.
CNT_W, 16, width of counters, snapshots and data bus.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
addr  in  16  CPU word address, qualified by re/we
re  in  1  read strobe, single cycle per access
we  in  1  write strobe, single cycle per access
wdata  in  CNT_W  write data
rdata  out  CNT_W  read data, valid only with rd_valid, else 0
rd_valid  out  1  registered read acknowledge for in-range reads
br_cnt_in  in  CNT_W  live branch count
hit_cnt_in  in  CNT_W  live hit count
mispr_cnt_in  in  CNT_W  live mispredict count
timer_in  in  CNT_W  live timer
clr_cnts  out  1  one-cycle clear pulse to counter block

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0 CTRL: bit0 SNAP (W1, self-clear, reads 0); bit1 CLR (W1, self-clear, reads 0); bit2 AUTO (R/W); bit3 SNAP_VALID (RO); bits 15:4 read 0.
  - 1 BR_SNAP (RO); 2 HIT_SNAP (RO); 3 MISPR_SNAP (RO); 4 TIMER_SNAP (RO).
  - 5 LFSR (RO, live); 6 SNAP_AGE (RO); 7 reserved, reads 0.
  - Writes to RO offsets are ignored.
- Reset values: rdata=0, rd_valid=0, clr_cnts=0, all snapshots=0, AUTO=0, SNAP_VALID=0, SNAP_AGE=0, LFSR=16'hACE1.
- Read: re with in-range addr at cycle N -> rd_valid=1 and rdata=register value sampled at N, both registered, during cycle N+1 only. Out-of-range addr -> no response, rd_valid stays 0 and rdata stays 0.
- re and we asserted together: the write is performed, the read is dropped, rd_valid=0.
- SNAP write at cycle N: at edge ending N, all four snapshots load the *_in values of cycle N. SNAP_VALID<=1, SNAP_AGE<=0.
- CLR write at cycle N: clr_cnts=1 for exactly cycle N+1. Snapshots are not cleared.
- SNAP and CLR in the same write: the snapshot holds pre-clear values.
- AUTO=1: snapshots load every cycle, SNAP_VALID=1, SNAP_AGE held 0. A read at N returns *_in from N-1.
- SNAP_AGE: +1 per cycle while AUTO=0, saturates at 16'hFFFF with no wrap.
- LFSR: Fibonacci, shift left, feedback = b15^b14^b12^b3 into b0, advances every cycle. It never reaches 0.
- Async reset mid-access cancels any pending rd_valid/clr_cnts immediately.

Test Plan:
1. Release reset, re addr=BASE+5 in the first cycle, then again the next cycle -> rdata 16'hACE1, then 16'h59C3, each with rd_valid=1 for one cycle.
2. Snapshot hold: drive br=16'h0010, hit=16'h000C, mispr=16'h0004, timer=16'h1234; write CTRL=16'h0001; change all inputs to 16'hFFFF; read offsets 1-4 -> 16'h0010, 16'h000C, 16'h0004, 16'h1234; read CTRL -> 16'h0008.
3. Snapshot with clear: inputs br=16'h0020, write CTRL=16'h0003 -> clr_cnts high exactly one cycle after the write cycle; BR_SNAP reads 16'h0020; CTRL reads 16'h0008.
4. Age saturation: SNAP write, wait 10 cycles and read offset 6 -> 16'h000A (±1 per read-timing offset, checked exactly by the bench); wait 70000 cycles -> 16'hFFFF.
5. Address decode: reads at BASE+8 and 16'h0000 -> rd_valid stays 0; read at BASE+7 -> rd_valid=1, rdata=0; re+we together at BASE+0 with 16'h0004 -> no rd_valid, then CTRL reads 16'h000C.
6. Auto mode: write CTRL=16'h0004, ramp br_cnt_in by 1 per cycle, read BR_SNAP -> returns the br_cnt_in value from the cycle before re; assert rst_n low mid-read -> rd_valid drops immediately.
